// File: rtl/seq_add_pkg.sv
// Shared types and constants for the sequential nibble adder controller.
package seq_add_pkg;

  localparam int NIBBLE_W    = 4;
  localparam int MAX_NIBBLES = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_add_state_t;

endpackage

// File: rtl/nibble_adder.sv
// Combinational 4-bit adder slice with carry-in and carry-out.
module nibble_adder
  import seq_add_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  // Widen by one bit so the slice carry-out falls out of the add.
  always_comb begin
    {cout, sum} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};
  end

endmodule

// File: rtl/seq_add_ctrl.sv
// Sequential wide adder: one shared nibble_adder slice walks the operands
// LSB nibble first, carrying between nibbles through a register.
// Optional macro SEQ_ADD_SUB_EN adds the in_sub port (A - B via ~B + 1).
module seq_add_ctrl
  import seq_add_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0] in_a,
  input  logic [NIBBLE_W*NIBBLES-1:0] in_b,
  input  logic                        in_cin,
`ifdef SEQ_ADD_SUB_EN
  input  logic                        in_sub,
`endif
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0] out_sum,
  output logic                        out_carry,
  output logic                        busy
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  seq_add_state_t                     state_q;
  logic [NIBBLES-1:0][NIBBLE_W-1:0]   a_q;
  logic [NIBBLES-1:0][NIBBLE_W-1:0]   b_q;
  logic [NIBBLES-1:0][NIBBLE_W-1:0]   sum_q;
  logic                               carry_q;
  logic                               cout_q;
  logic [IDX_W-1:0]                   idx_q;

  logic [W-1:0]                       b_cap;
  logic                               c_cap;
  logic [NIBBLE_W-1:0]                nib_sum;
  logic                               nib_cout;
  logic                               accept;

  // Handshake signals depend only on state and out_ready, never on in_valid.
  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign accept    = in_valid && in_ready;
  assign out_sum   = sum_q;
  assign out_carry = cout_q;

  // Operand B and initial carry as captured; subtract folds into ~B + 1.
  always_comb begin
    b_cap = in_b;
    c_cap = in_cin;
`ifdef SEQ_ADD_SUB_EN
    if (in_sub) begin
      b_cap = ~in_b;
      c_cap = 1'b1;
    end
`endif
  end

  nibble_adder u_nib (
    .a    (a_q[idx_q]),
    .b    (b_q[idx_q]),
    .cin  (carry_q),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  // Sequencer: capture on accept, one nibble per RUN cycle, hold in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else if (accept) begin
      // Accept is only possible in IDLE or DONE, so RUN is never interrupted.
      state_q <= RUN;
      a_q     <= in_a;
      b_q     <= b_cap;
      carry_q <= c_cap;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        RUN: begin
          sum_q[idx_q] <= nib_sum;
          carry_q      <= nib_cout;
          if (idx_q == LAST_IDX) begin
            state_q <= DONE;
            cout_q  <= nib_cout;
            idx_q   <= '0;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        IDLE: ;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_add_ctrl.sv
// Bench for seq_add_ctrl (NIBBLES=4): directed vectors with literal
// expectations plus a per-cycle comparison against a transaction model.
module tb_seq_add_ctrl;
  import seq_add_pkg::*;

  localparam int NIB = 4;
  localparam int W   = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, in_cin, in_sub;
  logic [W-1:0] in_a, in_b;
  logic         out_valid, out_ready, out_carry, busy;
  logic [W-1:0] out_sum;

  int n_chk  = 0;
  int n_fail = 0;

  // Transaction-level model state.
  bit       mdl_on     = 1'b0;
  bit       mdl_busy   = 1'b0;
  int       mdl_cnt    = 0;
  logic [W:0] mdl_exp  = '0;
  bit       idle_known = 1'b0;

  always #5 clk = ~clk;

  seq_add_ctrl #(.NIBBLES(NIB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
`ifdef SEQ_ADD_SUB_EN
    .in_sub    (in_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .busy      (busy)
  );

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic c, input logic s);
    logic [W-1:0] bb;
    logic         cc;
    bb = b;
    cc = c;
`ifdef SEQ_ADD_SUB_EN
    if (s) begin
      bb = ~b;
      cc = 1'b1;
    end
`else
    if (s) cc = c;
`endif
    return {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cc};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, then advance the model for the next edge.
  always @(negedge clk) begin : cmp
    logic        ev, er;
    logic [31:0] m;
    if (rst_n && mdl_on) begin
      ev = mdl_busy && (mdl_cnt >= NIB);
      er = !mdl_busy || (ev && out_ready);
      chk("cmp_out_valid", {31'b0, out_valid}, {31'b0, ev});
      chk("cmp_in_ready",  {31'b0, in_ready},  {31'b0, er});
      chk("cmp_busy",      {31'b0, busy},      {31'b0, mdl_busy});
      if (mdl_busy) begin
        m = (32'h1 << (4 * ((mdl_cnt > NIB) ? NIB : mdl_cnt))) - 32'h1;
        chk("cmp_sum",   {16'b0, out_sum}, {16'b0, mdl_exp[W-1:0] & m[W-1:0]});
        chk("cmp_carry", {31'b0, out_carry}, {31'b0, ev ? mdl_exp[W] : 1'b0});
      end else if (idle_known) begin
        chk("cmp_sum_rst",   {16'b0, out_sum}, 32'h0);
        chk("cmp_carry_rst", {31'b0, out_carry}, 32'h0);
      end
      if (in_valid && er) begin
        mdl_busy   = 1'b1;
        mdl_cnt    = 0;
        mdl_exp    = model(in_a, in_b, in_cin, in_sub);
        idle_known = 1'b0;
      end else if (ev && out_ready) begin
        mdl_busy = 1'b0;
      end else if (mdl_busy) begin
        mdl_cnt++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic c, input logic s);
    int t;
    in_a = a; in_b = b; in_cin = c; in_sub = s; in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 100) begin
      step();
      t++;
    end
    if (t >= 100) chk("send_timeout", 32'(t), 32'h0);
    step();
    in_valid = 1'b0;
  endtask

  // Called right after the accept edge; checks latency and the literal result.
  task automatic wait_result(input string nm, input logic [W-1:0] es, input logic ec);
    int lat;
    lat = 0;
    do begin
      step();
      lat++;
    end while (!out_valid && lat < 100);
    chk({nm, "_latency"}, 32'(lat), 32'(NIB));
    chk({nm, "_sum"},   {16'b0, out_sum},   {16'b0, es});
    chk({nm, "_carry"}, {31'b0, out_carry}, {31'b0, ec});
  endtask

  task automatic model_reset();
    mdl_busy   = 1'b0;
    mdl_cnt    = 0;
    mdl_exp    = '0;
    idle_known = 1'b1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0;
    in_sub = 1'b0; out_ready = 1'b1;
    #12;
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_out_sum",   {16'b0, out_sum},   32'h0);
    chk("rst_out_carry", {31'b0, out_carry}, 32'h0);
    chk("rst_busy",      {31'b0, busy},      32'h0);
    #9 rst_n = 1'b1;
    model_reset();
    mdl_on = 1'b1;
    #1 chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
    step();

    // Basic add and full ripple cases.
    send(16'h1234, 16'h0001, 1'b0, 1'b0);
    wait_result("basic", 16'h1235, 1'b0);
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    wait_result("ripple", 16'h0000, 1'b1);
    send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    wait_result("ripple_cin", 16'hFFFF, 1'b1);
    step();

    // Backpressure: result held, no new accept while out_ready is low.
    out_ready = 1'b0;
    send(16'hA5A5, 16'h1111, 1'b0, 1'b0);
    wait_result("bp", 16'hB6B6, 1'b0);
    repeat (3) begin
      step();
      chk("bp_in_ready",  {31'b0, in_ready},  32'h0);
      chk("bp_out_valid", {31'b0, out_valid}, 32'h1);
      chk("bp_sum",       {16'b0, out_sum},   32'h0000B6B6);
    end
    out_ready = 1'b1;
    step();
    chk("bp_idle_valid", {31'b0, out_valid}, 32'h0);
    chk("bp_idle_busy",  {31'b0, busy},      32'h0);

    // Back-to-back: second request held through RUN, accepted on the handshake edge.
    out_ready = 1'b0;
    send(16'h1111, 16'h2222, 1'b0, 1'b0);
    in_a = 16'h4000; in_b = 16'hC000; in_cin = 1'b0; in_valid = 1'b1;
    wait_result("b2b_first", 16'h3333, 1'b0);
    out_ready = 1'b1;
    #1 chk("b2b_in_ready", {31'b0, in_ready}, 32'h1);
    step();
    in_valid = 1'b0;
    chk("b2b_busy",  {31'b0, busy},      32'h1);
    chk("b2b_valid", {31'b0, out_valid}, 32'h0);
    wait_result("b2b_second", 16'h0000, 1'b1);
    step();
    step();

    // Reset after two nibbles of a RUN.
    send(16'h1234, 16'h4321, 1'b0, 1'b0);
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, out_valid}, 32'h0);
    chk("mid_rst_sum",   {16'b0, out_sum},   32'h0);
    chk("mid_rst_busy",  {31'b0, busy},      32'h0);
    model_reset();
    #1 rst_n = 1'b1;
    #1 chk("mid_rst_ready", {31'b0, in_ready}, 32'h1);
    step();
    send(16'h0F0F, 16'h0101, 1'b0, 1'b0);
    wait_result("post_rst", 16'h1010, 1'b0);
    step();

`ifdef SEQ_ADD_SUB_EN
    send(16'h0005, 16'h0007, 1'b0, 1'b1);
    wait_result("sub_borrow", 16'hFFFE, 1'b0);
    send(16'h0009, 16'h0003, 1'b0, 1'b1);
    wait_result("sub_nob", 16'h0006, 1'b1);
    step();
`endif

    step();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_add_ctrl.md
# seq_add_ctrl

Multi-cycle controller that computes wide additions by sequencing one shared 4-bit adder slice over successive nibbles, least significant first, with a registered carry. Operands arrive through a valid/ready input handshake. Results leave through a valid/ready output handshake. The block sits between a requesting datapath and the 4-bit adder slice, and it trades latency for area.

## Interface
- `NIBBLES`, default 4: number of 4-bit slices. Operand width is W = 4*NIBBLES. Legal range is 1–16.
- `clk` input, 1: single clock. All state updates on the rising edge.
- `rst_n` input, 1: reset, asynchronous and active-low.
- `in_valid` input, 1: operand request.
- `in_ready` output, 1: block can accept operands.
- `in_a` input, W: operand A.
- `in_b` input, W: operand B.
- `in_cin` input, 1: carry-in to nibble 0.
- `in_sub` input, 1: subtract request. This port exists only when `SEQ_ADD_SUB_EN` is defined.
- `out_valid` output, 1: result available.
- `out_ready` input, 1: consumer accepts the result.
- `out_sum` output, W: result.
- `out_carry` output, 1: carry-out of the top nibble.
- `busy` output, 1: high in RUN and DONE.

## Operation
- **FSM states:** IDLE, RUN, DONE. On reset the state is IDLE.
- **Reset values:** all registers clear to 0. `out_valid`=0, `out_sum`=0, `out_carry`=0, `busy`=0. `in_ready`=1 once `rst_n` is released.
- **Operand accept:** an accept occurs when `in_valid && in_ready` on a rising edge. At that edge the block:
  - captures A, B and carry (`in_cin`), sets nibble index idx=0, and moves to RUN;
  - clears `out_sum` and `out_carry` to 0.
- **Inputs after capture:** operand inputs are don't-care after the accept edge.
- **RUN, each cycle:**
  - the adder slice computes A[idx] + B[idx] + carry;
  - the 4-bit sum is written into `out_sum` nibble idx, and the slice carry-out is written into the carry register;
  - idx increments. When idx = NIBBLES-1 the state moves to DONE and the final carry goes to `out_carry`.
- **DONE:** `out_valid`=1. `out_sum` and `out_carry` are held stable until `out_valid && out_ready`.
- **Leaving DONE:** on that output handshake the state goes to IDLE, or goes directly to RUN if a new accept happens on the same edge.
- **in_ready:** `in_ready` = (state==IDLE) || (state==DONE && `out_ready`). This allows back-to-back operations with no bubble.
- **Width rules:** modulo-2^W arithmetic; `out_carry` is bit W of the true sum. The carry register is reset to `in_cin` on every accept and is never carried across operations.
- **Reset mid-operation:** deasserting `rst_n` in RUN or DONE aborts the operation immediately (asynchronous). The partial result is discarded and `out_valid` drops to 0 without a handshake.
- **in_valid outside IDLE:** if `in_valid` is high while in RUN, it is ignored and no capture occurs. The requester must hold the request until `in_ready`.

## Timing
- If the accept happens at edge k, nibble i is written at edge k+1+i.
- `out_valid` rises after edge k+NIBBLES. Latency is NIBBLES cycles from accept to `out_valid`.
- Throughput: one operation per NIBBLES cycles when `out_ready` is held high.
- `in_ready` and `out_valid` are combinational from state and `out_ready` only. There is no combinational path from `in_valid` to any output.

## Configuration
- `SEQ_ADD_SUB_EN` defined:
  - the `in_sub` port exists and is captured at accept;
  - when `in_sub`=1, B is inverted at capture and the initial carry is forced to 1, so the result is A - B - 0;
  - `out_carry`=1 means no borrow.
- `SEQ_ADD_SUB_EN` undefined: the port is absent and the block adds only.

## Structure
- **Package `seq_add_pkg`:**
  - state enum `seq_add_state_t` (IDLE, RUN, DONE);
  - localparam `NIBBLE_W`=4;
  - localparam `MAX_NIBBLES`=16.
- **Sub-module `nibble_adder`:** combinational 4-bit sum with carry-in and carry-out. It is instantiated once and shared across all nibbles by the idx mux.
- **Index width:** idx width is $clog2(NIBBLES), with a minimum of 1.

## Test plan
All scenarios use NIBBLES=4.
- **Basic add:** A=16'h1234, B=16'h0001, cin=0 → `out_sum`=16'h1235, `out_carry`=0, `out_valid` exactly 4 cycles after accept.
- **Full ripple:** A=16'hFFFF, B=16'h0001 → `out_sum`=16'h0000, `out_carry`=1. Also with cin=1 and A=B=16'hFFFF → `out_sum`=16'hFFFF, `out_carry`=1.
- **Backpressure:** `out_ready`=0 for 3 cycles in DONE → `out_sum`/`out_carry` stable, `in_ready`=0 throughout. On `out_ready`=1 → handshake, then IDLE.
- **Back-to-back:** second request held while the first is in DONE with `out_ready`=1 → accepted on the same edge as the output handshake, and the second result arrives 4 cycles later.
- **Reset mid-RUN:** `rst_n` pulsed low after 2 nibbles → `out_valid`=0, `out_sum`=0, `busy`=0. The next operation A=16'h0F0F, B=16'h0101 gives 16'h1010 correctly.
- **Subtract (`SEQ_ADD_SUB_EN`):** A=16'h0005, B=16'h0007, sub=1 → `out_sum`=16'hFFFE, `out_carry`=0. A=16'h0009, B=16'h0003 → 16'h0006, `out_carry`=1.
